// File: rtl/seg_scan_ctrl_pkg.sv
// Common types and constants for the multiplexed 7-segment scan controller.
`include "seg_defs.vh"

package seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = `SEG_NUM_DIGITS;
  localparam int SEG_W      = `SEG_WIDTH;
  localparam int DIG_W      = $clog2(NUM_DIGITS);
  localparam int PWM_W      = 4;

  localparam logic [NUM_DIGITS-1:0] EN_ALL_OFF = `SEG_EN_ALL_OFF;

  typedef logic [DIG_W-1:0] digit_t;

  // Active-low enable pattern with only digit d driven.
  function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_t d);
    logic [NUM_DIGITS-1:0] en;
    en    = EN_ALL_OFF;
    en[d] = 1'b0;
    return en;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot/blank timing for the digit scan.
// The counters hold the coordinates of the cycle that begins at the next
// rising edge, so the parent can register its outputs and still have them
// line up with the slot they belong to. slot_end/frame_end flag the cycle
// now running as the last cycle of a slot / of digit 3's slot. run_q keeps
// the very first edge after reset from looking like a frame boundary.
module scan_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 4096,
  parameter int BLANK_CYC = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  output logic   slot_end,
  output logic   frame_end,
  output logic   in_blank,
  output digit_t digit
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_t           digit_q, digit_d;
  logic             run_q, run_d;

  // Advance the slot counter; step to the next digit when a slot completes.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    run_d   = 1'b1;
    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
      cnt_d   = '0;
      digit_d = digit_q + digit_t'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      digit_q <= '0;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      run_q   <= run_d;
    end
  end

  assign slot_end  = run_q && (cnt_q == '0);
  assign frame_end = slot_end && (digit_q == '0);
  assign in_blank  = (cnt_q < CNT_W'(BLANK_CYC));
  assign digit     = digit_q;

endmodule

// File: rtl/seg_defs.vh
// Shared display geometry: digit count, segment width and the all-off
// (active-low) digit enable pattern.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH

`define SEG_NUM_DIGITS 4
`define SEG_WIDTH      7
`define SEG_EN_ALL_OFF 4'b1111

`endif

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with PWM brightness and
// frame-synchronous shadow registers for the display contents.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 4096,
  parameter int BLANK_CYC = 64
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_DIGITS*SEG_W-1:0] SEG_DATA,
  input  logic [NUM_DIGITS-1:0]       DIGIT_MASK,
  input  logic [PWM_W-1:0]            BRIGHT,
  input  logic                        LOAD_REQ,
  output logic                        LOAD_ACK,
  output logic                        FRAME_DONE,
  output logic [NUM_DIGITS-1:0]       DS_EN,
  output logic [SEG_W-1:0]            DS_SEG
);

  logic   slot_end;
  logic   frame_end;
  logic   in_blank;
  digit_t digit;

  scan_timer #(
    .CLK_DIV  (CLK_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .slot_end (slot_end),
    .frame_end(frame_end),
    .in_blank (in_blank),
    .digit    (digit)
  );

  logic [NUM_DIGITS*SEG_W-1:0] seg_sh_q, seg_sh_d;
  logic [NUM_DIGITS-1:0]       mask_sh_q, mask_sh_d;
  logic [PWM_W-1:0]            bright_sh_q, bright_sh_d;
  logic [PWM_W-1:0]            pwm_q, pwm_d;
  logic                        ack_q, ack_d;
  logic                        done_q, done_d;
  logic [NUM_DIGITS-1:0]       en_q, en_d;
  logic [SEG_W-1:0]            dseg_q, dseg_d;
  logic                        lit;

  // Shadow latch at frame boundaries, PWM phase and next-cycle drive values.
  // The PWM counter parks at all-ones outside ON so it reads 0 on the first
  // ON cycle of every slot.
  always_comb begin
    seg_sh_d    = seg_sh_q;
    mask_sh_d   = mask_sh_q;
    bright_sh_d = bright_sh_q;
    ack_d       = 1'b0;
    done_d      = frame_end;
    if (frame_end && LOAD_REQ) begin
      seg_sh_d    = SEG_DATA;
      mask_sh_d   = DIGIT_MASK;
      bright_sh_d = BRIGHT;
      ack_d       = 1'b1;
    end

    pwm_d = (slot_end || in_blank) ? '1 : pwm_q + PWM_W'(1);

    lit    = !in_blank && (pwm_d <= bright_sh_d) && mask_sh_d[digit];
    en_d   = EN_ALL_OFF;
    dseg_d = '0;
    if (lit) begin
      en_d   = digit_enable(digit);
      dseg_d = seg_sh_d[digit*SEG_W +: SEG_W];
    end
  end

  // Shadow, PWM and output registers; reset forces the display dark at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_sh_q    <= '0;
      mask_sh_q   <= '0;
      bright_sh_q <= '0;
      pwm_q       <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= EN_ALL_OFF;
      dseg_q      <= '0;
    end else begin
      seg_sh_q    <= seg_sh_d;
      mask_sh_q   <= mask_sh_d;
      bright_sh_q <= bright_sh_d;
      pwm_q       <= pwm_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      en_q        <= en_d;
      dseg_q      <= dseg_d;
    end
  end

  assign LOAD_ACK   = ack_q;
  assign FRAME_DONE = done_q;
  assign DS_EN      = en_q;
  assign DS_SEG     = dseg_q;

endmodule
